seq_pattern_tx: RTL and testbench



---
 rtl/seq_pattern_tx.sv | 133 +++++++++++++
 tb/tb_seq_pattern_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern transmitter: sends a captured word MSB-first with an optional repeat and idle gap.
// Latency: first bit is valid one cycle after the accepted start edge; done follows the final bit.
// Backpressure: none downstream; start is accepted only while ready=1 and ignored otherwise.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               transfer request, sampled only in IDLE
//   pattern/length      word to send and number of bits (bit length-1 goes first, 1..WIDTH legal)
//   repeat_cnt          extra repetitions after the first pass (0 = send once)
//   ready               high while IDLE (combinational state decode)
//   tx_bit/tx_valid     registered serial data and its qualifier
//   done                one-cycle pulse after the last bit of the last repetition
//   err                 one-cycle pulse when start arrives with an out-of-range length
module seq_pattern_tx #(
  parameter int WIDTH      = 32,
  parameter int LEN_W      = 6,
  parameter int REP_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             done,
  output logic             err
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // The gap counter only ever holds GAP_CYCLES-1 down to 0.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [IDX_W-1:0] idx;       // index of the bit currently on tx_bit
  logic [IDX_W-1:0] last_idx;  // captured length-1, reload value for each repetition
  logic [REP_W-1:0] reps;
  logic [GAP_W-1:0] gap_cnt;

  logic             legal_len;
  logic [IDX_W-1:0] start_idx;

  assign legal_len = (length != '0) && (length <= MAX_LEN);
  assign start_idx = IDX_W'(length - LEN_W'(1));
  assign ready     = (state == IDLE);

  // tx_bit is loaded one edge ahead of the cycle it is shown in, so the
  // register always holds pat_q[idx] while idx names the bit on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pat_q    <= '0;
      idx      <= '0;
      last_idx <= '0;
      reps     <= '0;
      gap_cnt  <= '0;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (legal_len) begin
              pat_q    <= pattern;
              last_idx <= start_idx;
              idx      <= start_idx;
              reps     <= repeat_cnt;
              tx_bit   <= pattern[start_idx];
              tx_valid <= 1'b1;
              state    <= SHIFT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (idx == '0) begin
            if (reps != '0) begin
              reps <= reps - REP_W'(1);
              if (GAP_CYCLES > 0) begin
                state    <= GAP;
                gap_cnt  <= GAP_LOAD;
                tx_bit   <= 1'b0;
                tx_valid <= 1'b0;
              end else begin
                // Back-to-back repetition: restart the word with no bubble.
                idx    <= last_idx;
                tx_bit <= pat_q[last_idx];
              end
            end else begin
              state    <= DONE;
              done     <= 1'b1;
              tx_bit   <= 1'b0;
              tx_valid <= 1'b0;
            end
          end else begin
            idx    <= idx - IDX_W'(1);
            tx_bit <= pat_q[idx - IDX_W'(1)];
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state    <= SHIFT;
            idx      <= last_idx;
            tx_bit   <= pat_q[last_idx];
            tx_valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: queue-based output model plus directed literal checks.
module tb_seq_pattern_tx;

  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pattern;
  logic [5:0]  length;
  logic [3:0]  repeat_cnt;

  logic ready, tx_bit, tx_valid, done, err;
  logic ready0, tx_bit0, tx_valid0, done0, err0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(32), .LEN_W(6), .REP_W(4), .GAP_CYCLES(GAP)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .repeat_cnt(repeat_cnt), .ready(ready), .tx_bit(tx_bit), .tx_valid(tx_valid),
    .done(done), .err(err)
  );

  seq_pattern_tx #(.WIDTH(32), .LEN_W(6), .REP_W(4), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .repeat_cnt(repeat_cnt), .ready(ready0), .tx_bit(tx_bit0), .tx_valid(tx_valid0),
    .done(done0), .err(err0)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- model: per-cycle expected outputs as a queue ----------------
  typedef struct packed { logic v; logic b; logic d; } ent_t;
  ent_t exp_q[$];
  ent_t cur      = '0;
  logic cur_busy = 1'b0;
  logic cur_err  = 1'b0;
  logic new_err;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        cur      = '0;
        cur_busy = 1'b0;
        cur_err  = 1'b0;
      end else begin
        new_err = 1'b0;
        if (!cur_busy && start) begin
          if (length >= 6'd1 && length <= 6'd32) begin
            for (int r = 0; r <= int'(repeat_cnt); r++) begin
              if (r > 0)
                for (int g = 0; g < GAP; g++) exp_q.push_back('{1'b0, 1'b0, 1'b0});
              for (int i = int'(length) - 1; i >= 0; i--)
                exp_q.push_back('{1'b1, pattern[i], 1'b0});
            end
            exp_q.push_back('{1'b0, 1'b0, 1'b1});
          end else begin
            new_err = 1'b1;
          end
        end
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          cur_busy = 1'b1;
        end else begin
          cur      = '0;
          cur_busy = 1'b0;
        end
        cur_err = new_err;
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    chk("cycle_outputs", 128'({ready, tx_valid, tx_bit, done, err}),
        128'({~cur_busy, cur.v, cur.b, cur.d, cur_err}));
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_start(input logic [31:0] p, input logic [5:0] l, input logic [3:0] r);
    @(negedge clk);
    pattern    = p;
    length     = l;
    repeat_cnt = r;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    // scramble inputs after capture; the transfer must not notice
    pattern    = ~p;
    length     = 6'd0;
    repeat_cnt = 4'hF;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (ready) break;
      @(negedge clk);
    end
    chk("wait_idle", 128'(ready), 128'(1'b1));
  endtask

  logic [31:0] vseq;
  logic [15:0] bits16;
  logic [95:0] bits96;
  int          k, cnt;
  logic        seen;

  initial begin
    reset = 1'b1; start = 1'b0; pattern = '0; length = '0; repeat_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 128'({ready, tx_valid, tx_bit, done, err}), 128'(5'b10000));
    chk("reset_state_gap0", 128'({ready0, tx_valid0, tx_bit0, done0, err0}), 128'(5'b10000));
    reset = 1'b0;

    // 1: two ones, single pass
    drive_start(32'h3, 6'd2, 4'd0);
    chk("t1_bit1", 128'({tx_valid, tx_bit, ready}), 128'(3'b110));
    @(negedge clk);
    chk("t1_bit2", 128'({tx_valid, tx_bit, ready}), 128'(3'b110));
    @(negedge clk);
    chk("t1_done", 128'({tx_valid, done, ready}), 128'(3'b010));
    @(negedge clk);
    chk("t1_ready", 128'({ready, done}), 128'(2'b10));

    // 2: 8'hA5 twice with a 2-cycle gap
    drive_start(32'hA5, 6'd8, 4'd1);
    k = 0; vseq = '0; bits16 = '0; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      k++;
      vseq = {vseq[30:0], tx_valid};
      if (tx_valid) bits16 = {bits16[14:0], tx_bit};
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t2_done_seen", 128'(seen), 128'(1'b1));
    chk("t2_cycles", 128'(k), 128'(19));
    chk("t2_valid_shape", 128'(vseq[18:0]), 128'(19'b1111111100111111110));
    chk("t2_bits", 128'(bits16), 128'(16'hA5A5));
    wait_idle();

    // 3: illegal lengths
    @(negedge clk);
    pattern = 32'hF; length = 6'd0; start = 1'b1;
    @(negedge clk);
    chk("t3_err_len0", 128'({ready, tx_valid, err}), 128'(3'b101));
    length = 6'd33;
    @(negedge clk);
    chk("t3_err_len33", 128'({ready, tx_valid, err}), 128'(3'b101));
    start = 1'b0; length = 6'd4;
    @(negedge clk);
    chk("t3_err_clear", 128'({ready, tx_valid, err}), 128'(3'b100));

    // 4: full-width word three times, back-to-back on the gapless instance
    drive_start(32'h8000_0001, 6'd32, 4'd2);
    cnt = 0; k = 0; bits96 = '0; seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      k++;
      if (tx_valid0) begin
        cnt++;
        bits96 = {bits96[94:0], tx_bit0};
      end
      if (done0) seen = 1'b1;
      else @(negedge clk);
    end
    chk("t4_valid_count", 128'(cnt), 128'(96));
    chk("t4_cycles", 128'(k), 128'(97));
    chk("t4_bits", 128'(bits96), 128'({3{32'h8000_0001}}));
    wait_idle();

    // 5: asynchronous reset in the 5th shift cycle
    drive_start(32'hFF, 6'd8, 4'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("t5_async_reset", 128'({ready, tx_valid, done}), 128'(3'b100));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("t5_no_done", 128'({done, ready}), 128'(2'b01));
    drive_start(32'h3, 6'd2, 4'd0);
    chk("t5_bit1", 128'({tx_valid, tx_bit}), 128'(2'b11));
    @(negedge clk);
    chk("t5_bit2", 128'({tx_valid, tx_bit}), 128'(2'b11));
    @(negedge clk);
    chk("t5_done", 128'(done), 128'(1'b1));
    wait_idle();

    // 6: start held through a whole transfer
    @(negedge clk);
    pattern = 32'h2; length = 6'd2; repeat_cnt = 4'd0; start = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_done", 128'({done, ready}), 128'(2'b10));
    @(negedge clk);
    chk("t6_ready_back", 128'({ready, tx_valid}), 128'(2'b10));
    @(negedge clk);
    chk("t6_restart", 128'({ready, tx_valid, tx_bit}), 128'(3'b011));
    start = 1'b0;
    @(negedge clk);
    wait_idle();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
